// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Single-outstanding load/store sequencer between the MEM
//                stage and data_memory. Checks funct3 legality and alignment,
//                holds the memory port stable for MEM_LATENCY cycles, and
//                returns load data or store completion over a valid/ready
//                response channel.
//  Revision    : 1.0  initial release
// ============================================================================
module load_store_unit #(
   parameter int MEM_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_is_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic [1:0]  resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   output logic [2:0]  mem_funct3,
   input  logic [31:0] mem_read_data
);

   // A counter of at least one bit keeps the MEM_LATENCY==1 case legal.
   localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_CNT_ZERO = '0;

   localparam logic [1:0] C_ERR_OK       = 2'b00;
   localparam logic [1:0] C_ERR_MISALIGN = 2'b01;
   localparam logic [1:0] C_ERR_ILLEGAL  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t            r_state;
   logic              r_is_store;
   logic [2:0]        r_funct3;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [CNT_W-1:0]  r_count;
   logic              r_req_ready;
   logic              r_resp_valid;
   logic [31:0]       r_resp_rdata;
   logic [1:0]        r_resp_error;

   logic              w_illegal;
   logic              w_misaligned;

   // Classify the incoming request; illegal encodings outrank misalignment.
   always_comb begin
      w_illegal    = 1'b0;
      w_misaligned = 1'b0;
      if (req_is_store) begin
         w_illegal = (req_funct3 >= 3'b011);
      end else begin
         w_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                     (req_funct3 == 3'b111);
      end
      w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
   end

   // Request/response sequencer with registered handshake and memory-port outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_is_store   <= 1'b0;
         r_funct3     <= 3'b000;
         r_addr       <= 32'h0;
         r_wdata      <= 32'h0;
         r_count      <= C_CNT_ZERO;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'h0;
         r_resp_error <= C_ERR_OK;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (req_valid) begin
                  // Latch even for rejected requests so the memory port always
                  // shows the most recently accepted request.
                  r_is_store  <= req_is_store;
                  r_funct3    <= req_funct3;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (w_illegal) begin
                     r_resp_error <= C_ERR_ILLEGAL;
                     r_resp_rdata <= 32'h0;
                     r_resp_valid <= 1'b1;
                     r_state      <= S_RESP;
                  end else if (w_misaligned) begin
                     r_resp_error <= C_ERR_MISALIGN;
                     r_resp_rdata <= 32'h0;
                     r_resp_valid <= 1'b1;
                     r_state      <= S_RESP;
                  end else begin
                     r_count <= C_CNT_LOAD;
                     r_state <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               if (r_count == C_CNT_ZERO) begin
                  // Memory extends and masks load data; stores report zero.
                  r_resp_rdata <= r_is_store ? 32'h0 : mem_read_data;
                  r_resp_error <= C_ERR_OK;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_count <= r_count - C_CNT_ONE;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_req_ready  <= 1'b1;
                  r_state      <= S_IDLE;
               end
            end
            default: begin
               r_state      <= S_IDLE;
               r_req_ready  <= 1'b1;
               r_resp_valid <= 1'b0;
            end
         endcase
      end
   end

   // Single write strobe on the final ACCESS cycle; rst squashes it immediately.
   assign mem_write_enable = (r_state == S_ACCESS) && r_is_store &&
                             (r_count == C_CNT_ZERO) && !rst;

   assign req_ready      = r_req_ready;
   assign resp_valid     = r_resp_valid;
   assign resp_rdata     = r_resp_rdata;
   assign resp_error     = r_resp_error;
   assign mem_address    = r_addr;
   assign mem_write_data = r_wdata;
   assign mem_funct3     = r_funct3;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Self-checking bench for load_store_unit at MEM_LATENCY 1 and 3
//                with a byte-array data memory per instance and a
//                transaction-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sel = 1'b0;
   logic        mem_clear = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_ready = 1'b0;

   logic [1:0]  d_req_ready, d_resp_valid, d_we;
   logic [31:0] d_rdata [2];
   logic [1:0]  d_err [2];
   logic [31:0] d_maddr [2];
   logic [31:0] d_mwdata [2];
   logic [2:0]  d_mf3 [2];
   logic [31:0] d_mrdata [2];

   logic        req_ready, resp_valid, mem_write_enable;
   logic [31:0] resp_rdata, mem_address, mem_write_data;
   logic [1:0]  resp_error;
   logic [2:0]  mem_funct3;

   logic [7:0]  ref_mem [2][1024];
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   // Read-side behaviour of data_memory: little-endian, extension by funct3.
   function automatic logic [31:0] ext(input logic [31:0] w, input logic [1:0] off,
                                       input logic [2:0] f3);
      logic [31:0] b;
      b = w >> (8 * off);
      case (f3)
         3'b000:  return {{24{b[7]}}, b[7:0]};
         3'b001:  return {{16{b[15]}}, b[15:0]};
         3'b010:  return w;
         3'b100:  return {24'h0, b[7:0]};
         3'b101:  return {16'h0, b[15:0]};
         default: return 32'h0;
      endcase
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [7:0] mem [0:1023];

      load_store_unit #(.MEM_LATENCY(g == 0 ? 1 : 3)) u_dut (
         .clk              (clk),
         .rst              (rst),
         .req_valid        (req_valid & (sel == (g != 0))),
         .req_ready        (d_req_ready[g]),
         .req_is_store     (req_is_store),
         .req_funct3       (req_funct3),
         .req_addr         (req_addr),
         .req_wdata        (req_wdata),
         .resp_valid       (d_resp_valid[g]),
         .resp_ready       (resp_ready & (sel == (g != 0))),
         .resp_rdata       (d_rdata[g]),
         .resp_error       (d_err[g]),
         .mem_address      (d_maddr[g]),
         .mem_write_data   (d_mwdata[g]),
         .mem_write_enable (d_we[g]),
         .mem_funct3       (d_mf3[g]),
         .mem_read_data    (d_mrdata[g])
      );

      assign d_mrdata[g] = ext({mem[{d_maddr[g][9:2], 2'd3}], mem[{d_maddr[g][9:2], 2'd2}],
                                mem[{d_maddr[g][9:2], 2'd1}], mem[{d_maddr[g][9:2], 2'd0}]},
                               d_maddr[g][1:0], d_mf3[g]);

      always @(posedge clk) begin
         if (mem_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h0;
         end else if (d_we[g]) begin
            mem[d_maddr[g][9:0]] <= d_mwdata[g][7:0];
            if (d_mf3[g][1:0] != 2'b00) mem[d_maddr[g][9:0] + 10'd1] <= d_mwdata[g][15:8];
            if (d_mf3[g][1:0] == 2'b10) begin
               mem[d_maddr[g][9:0] + 10'd2] <= d_mwdata[g][23:16];
               mem[d_maddr[g][9:0] + 10'd3] <= d_mwdata[g][31:24];
            end
         end
      end
   end

   assign req_ready        = d_req_ready[sel];
   assign resp_valid       = d_resp_valid[sel];
   assign mem_write_enable = d_we[sel];
   assign resp_rdata       = d_rdata[sel];
   assign resp_error       = d_err[sel];
   assign mem_address      = d_maddr[sel];
   assign mem_write_data   = d_mwdata[sel];
   assign mem_funct3       = d_mf3[sel];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Transaction-level reference: decide outcome, apply store bytes, read load.
   task automatic model(input int s, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [1:0] xe, output logic [31:0] xr);
      bit illegal, mis;
      int base, nbytes;
      illegal = st ? (f3 >= 3) : (f3 == 3 || f3 == 6 || f3 == 7);
      mis     = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
      xr = 32'h0;
      if (illegal) xe = 2'b10;
      else if (mis) xe = 2'b01;
      else begin
         xe = 2'b00;
         base = int'(a[9:0]);
         if (st) begin
            nbytes = (f3 == 0) ? 1 : (f3 == 1) ? 2 : 4;
            for (int i = 0; i < nbytes; i++) ref_mem[s][base + i] = wd[8*i +: 8];
         end else begin
            base = base & ~3;
            xr = ext({ref_mem[s][base+3], ref_mem[s][base+2], ref_mem[s][base+1],
                      ref_mem[s][base]}, a[1:0], f3);
         end
      end
   endtask

   // One full request/response transaction with optional response backpressure.
   task automatic do_req(input bit s, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int hold,
                         input bit junk, input logic [1:0] xe, input logic [31:0] xr);
      int g, k, we_cnt, lat;
      bit ok_busy, ok_hold;
      sel = s; req_valid = 1'b0; resp_ready = 1'b0;
      @(negedge clk);
      g = 0;
      while (!req_ready && g < 20) begin @(negedge clk); g++; end
      chk("req_ready_idle", {31'h0, req_ready}, 32'h1);
      req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
      lat = (xe != 2'b00) ? 1 : ((s ? 3 : 1) + 1);
      k = 1; we_cnt = 0; ok_busy = 1'b1;
      while (!resp_valid && k < 20) begin
         if (mem_write_enable) we_cnt++;
         if (req_ready !== 1'b0 || mem_address !== a || mem_funct3 !== f3 ||
             mem_write_data !== wd) ok_busy = 1'b0;
         @(negedge clk); k++;
      end
      if (mem_write_enable) we_cnt++;
      chk("resp_latency", k, lat);
      chk("busy_port", {31'h0, ok_busy}, 32'h1);
      chk("resp_error", {30'h0, resp_error}, {30'h0, xe});
      chk("resp_rdata", resp_rdata, xr);
      ok_hold = 1'b1;
      for (int h = 0; h < hold; h++) begin
         if (junk) begin
            req_valid = 1'b1; req_is_store = 1'($urandom);
            req_funct3 = 3'b010; req_addr = $urandom & 32'h3FC;
         end
         @(negedge clk);
         if (mem_write_enable) we_cnt++;
         if (!resp_valid || resp_error !== xe || resp_rdata !== xr || req_ready ||
             mem_address !== a) ok_hold = 1'b0;
      end
      if (hold > 0) chk("resp_held", {31'h0, ok_hold}, 32'h1);
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0; req_valid = 1'b0;
      chk("we_pulses", we_cnt, (xe == 2'b00 && st) ? 1 : 0);
      chk("after_handshake", {30'h0, resp_valid, req_ready}, 32'h1);
      if (junk) begin
         @(negedge clk);
         chk("junk_ignored", {30'h0, resp_valid, req_ready}, 32'h1);
      end
   endtask

   typedef struct {
      bit          s;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] wd;
      logic [1:0]  xe;
      logic [31:0] xr;
   } vec_t;

   initial begin
      vec_t        tbl[$];
      logic [1:0]  xe;
      logic [31:0] xr, a, wd;
      logic [2:0]  f3;
      logic        st;
      bit          s, quiet;

      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 1024; i++) ref_mem[m][i] = 8'h0;

      repeat (3) @(negedge clk);
      mem_clear = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         sel = 1'(m);
         #1;
         chk("rst_handshake", {29'h0, req_ready, resp_valid, mem_write_enable}, 32'h4);
         chk("rst_resp", {resp_rdata[29:0], resp_error}, 32'h0);
         chk("rst_mem_port", mem_address | mem_write_data | {29'h0, mem_funct3}, 32'h0);
      end

      tbl.push_back('{0, 1, 3'b010, 32'd100, 32'hDEADBEEF, 2'b00, 32'h0});
      tbl.push_back('{0, 0, 3'b010, 32'd100, 32'h0, 2'b00, 32'hDEADBEEF});
      tbl.push_back('{0, 1, 3'b001, 32'd201, 32'h1234, 2'b01, 32'h0});
      tbl.push_back('{0, 0, 3'b010, 32'd102, 32'h0, 2'b01, 32'h0});
      tbl.push_back('{0, 0, 3'b011, 32'd0, 32'h0, 2'b10, 32'h0});
      tbl.push_back('{0, 1, 3'b100, 32'd0, 32'h55, 2'b10, 32'h0});
      tbl.push_back('{0, 1, 3'b100, 32'd1, 32'h55, 2'b10, 32'h0});
      tbl.push_back('{1, 1, 3'b000, 32'd300, 32'hFFFFFF88, 2'b00, 32'h0});
      tbl.push_back('{1, 0, 3'b000, 32'd300, 32'h0, 2'b00, 32'hFFFFFF88});
      tbl.push_back('{1, 0, 3'b100, 32'd300, 32'h0, 2'b00, 32'h00000088});
      foreach (tbl[i]) begin
         model(tbl[i].s, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, xe, xr);
         do_req(tbl[i].s, tbl[i].st, tbl[i].f3, tbl[i].a, tbl[i].wd, 0, 1'b0,
                tbl[i].xe, tbl[i].xr);
      end

      // Backpressure with a competing request that must be ignored.
      do_req(1'b0, 1'b0, 3'b010, 32'd100, 32'h0, 3, 1'b1, 2'b00, 32'hDEADBEEF);

      // Reset during the store's only ACCESS cycle drops it entirely.
      sel = 1'b0;
      @(negedge clk);
      req_is_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'd400;
      req_wdata = 32'h11223344; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("we_last_access", {31'h0, mem_write_enable}, 32'h1);
      rst = 1'b1;
      #1;
      chk("we_rst_gate", {31'h0, mem_write_enable}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_handshake", {29'h0, req_ready, resp_valid, mem_write_enable}, 32'h4);
      chk("midrst_resp", {resp_rdata[29:0], resp_error}, 32'h0);
      chk("midrst_mem_port", mem_address | mem_write_data | {29'h0, mem_funct3}, 32'h0);
      quiet = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) quiet = 1'b0;
      end
      chk("midrst_no_resp", {31'h0, quiet}, 32'h1);
      do_req(1'b0, 1'b0, 3'b010, 32'd400, 32'h0, 0, 1'b0, 2'b00, 32'h0);

      // Randomized traffic on both latency variants against the reference model.
      repeat (300) begin
         s  = 1'($urandom);
         st = 1'($urandom);
         f3 = 3'($urandom);
         a  = ($urandom & 32'hFFFF_FC00) | ($urandom & 32'h3F);
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         wd = $urandom;
         model(s, st, f3, a, wd, xe, xr);
         do_req(s, st, f3, a, wd, $urandom_range(0, 2), 1'($urandom), xe, xr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
